counter_run_arbiter: RTL
========================

# counter_run_arbiter

Shares one 4-bit counter between two requesters. Each requester asks for a "run": the counter sweeps up from 0 to a requested length, or down from that length to 0. A round-robin FSM grants one run at a time, drives the shared counter, and reports completion. It sits between requester logic and the behavioural 4-bit counter datapath and replaces direct free-running use of that counter.

## Interface
- `WIDTH`, 4, counter and length width in bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 2: run request; bit i belongs to requester i and must be held until granted.
- `len0` input WIDTH: terminal length for requester 0; sampled at grant.
- `len1` input WIDTH: terminal length for requester 1; sampled at grant.
- `dir0` input 1: requester 0 direction; 1 = up (0→len), 0 = down (len→0); sampled at grant.
- `dir1` input 1: requester 1 direction; same encoding as `dir0`.
- `gnt` output 2: one-hot grant; high for the whole RUN state.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: single-cycle completion pulse.
- `done_id` output 1: index of the requester that finished; valid when `done` = 1.
- `out` output WIDTH: shared counter value.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (`rst`=1 at an edge) sets:
  - state IDLE; `gnt`=00, `busy`=0, `done`=0, `done_id`=0, `out`=0.
  - priority pointer `last`=1, so requester 0 wins the first tie.
- Reset overrides everything, including mid-RUN.
- IDLE:
  - If no `req` bit is set, stay in IDLE; `out` holds its value.
  - If exactly one bit is set, grant it.
  - If both are set, grant the requester ≠ `last`.
  - On a grant: latch len/dir of the winner, set `last` = winner, set `gnt` one-hot, go to RUN.
  - `out` loads its start value in the same edge: 0 if dir=1, len if dir=0.
- RUN:
  - Each edge: if `out` ≠ terminal (len if up, 0 if down), `out` steps ±1.
  - If `out` == terminal, go to DONE: `gnt`=00, `done`=1, `done_id`=winner, `out` holds.
- Length 0:
  - Start equals terminal, so RUN lasts one cycle with `out`=0, then DONE.
- Abort:
  - If the granted requester's `req` bit is 0 at a RUN edge, go to IDLE.
  - `gnt`=00, no `done` pulse, `out` holds the current value.
  - `last` keeps the aborted requester.
  - Abort takes priority over terminal detection in the same cycle.
- DONE: one cycle. `done` clears and state returns to IDLE. Requests are not evaluated in DONE.
- Changes to len/dir while granted are ignored; only the latched values are used.
- Arithmetic is unsigned WIDTH-bit. No wrap-around is possible because the sweep stops at its terminal value.
- `req`=11 with one requester stuck high: grants alternate strictly; neither side starves.

## Timing
- Request at IDLE edge t:
  - `gnt` and the start value are visible after edge t.
  - Terminal is reached after edge t+L, for a run of length L.
  - `done`=1 during the cycle after edge t+L+1.
  - IDLE after edge t+L+2.
- `gnt` is high for exactly L+1 cycles.
- Cycles between successive grant edges for back-to-back requests: L+3.
- `busy` = (state ≠ IDLE), registered with the state.
- Outputs change only on `clk` edges. No combinational path from `req` to `gnt`.

## Test plan
- Reset then single request, up:
  - Stimulus: `rst` high 2 cycles; `req`=01, `len0`=5, `dir0`=1.
  - Required: `gnt`=01 for 6 cycles with `out` 0,1,2,3,4,5.
  - Then `done`=1 with `done_id`=0 and `out`=5; `busy` low afterwards.
- Down run with length 0:
  - Stimulus: `req`=10, `len1`=0, `dir1`=0.
  - Required: one RUN cycle with `out`=0, then `done` with `done_id`=1.
  - Also: `req`=10, `len1`=3, `dir1`=0 must give `out` 3,2,1,0.
- Contention:
  - Stimulus: `req`=11 held for three runs, `len0`=`len1`=2.
  - Required: grant order 0, 1, 0.
  - Each grant edge is 5 cycles after the previous one.
- Abort:
  - Stimulus: `req0` run with `len0`=9, up; drop `req0` while `out`=4.
  - Required: next edge gives `gnt`=00, state IDLE, no `done` pulse, `out` holds 4.
- Reset mid-run:
  - Stimulus: assert `rst` while `out`=3 in RUN.
  - Required: next edge gives `out`=0, `gnt`=00, `busy`=0.
  - After reset with `req`=11, requester 0 wins.
- Input changes during a run:
  - Stimulus: change `len0` from 4 to 1 while granted.
  - Required: the run still ends at `out`=4.

Source files
------------

// File: rtl/counter_run_arbiter.sv
//------------------------------------------------------------------------------
// Module   : counter_run_arbiter
// Brief    : Round-robin owner of a shared up/down counter; grants one
//            0->len or len->0 run at a time and pulses done on completion.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_run_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             dir0,
    input  logic             dir1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;

    logic [1:0]       r_state;
    logic             r_last;     // most recent winner; also the active run's owner
    logic [WIDTH-1:0] r_len;
    logic             r_dir;
    logic [1:0]       r_gnt;
    logic             r_busy;
    logic             r_done;
    logic             r_done_id;
    logic [WIDTH-1:0] r_out;

    logic             w_win;
    logic [WIDTH-1:0] w_win_len;
    logic             w_win_dir;
    logic [WIDTH-1:0] w_term;

    // A lone request wins outright; a tie goes to whoever did not win last.
    assign w_win     = (req == 2'b11) ? ~r_last : req[1];
    assign w_win_len = w_win ? len1 : len0;
    assign w_win_dir = w_win ? dir1 : dir0;
    assign w_term    = r_dir ? r_len : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_s_idle;
            r_last    <= 1'b1;
            r_len     <= '0;
            r_dir     <= 1'b0;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_out     <= '0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    r_done <= 1'b0;
                    if (req != 2'b00) begin
                        r_last  <= w_win;
                        r_len   <= w_win_len;
                        r_dir   <= w_win_dir;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_out   <= w_win_dir ? '0 : w_win_len;
                        r_state <= c_s_run;
                    end
                end
                c_s_run: begin
                    // Withdrawal by the owner wins over reaching the terminal value.
                    if (!req[r_last]) begin
                        r_gnt   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= c_s_idle;
                    end else if (r_out == w_term) begin
                        r_gnt     <= 2'b00;
                        r_done    <= 1'b1;
                        r_done_id <= r_last;
                        r_state   <= c_s_done;
                    end else if (r_dir) begin
                        r_out <= r_out + WIDTH'(1);
                    end else begin
                        r_out <= r_out - WIDTH'(1);
                    end
                end
                c_s_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_s_idle;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign out     = r_out;

endmodule

`default_nettype wire
